imem_fetch_arbiter: RTL

- Sequences the single-port, byte-wide instruction memory that feeds top_cpu.
- Serves two requesters: CPU instruction fetch (16-bit, big-endian, two byte reads) and a host load/debug port (single-byte read/write).
- Alternating priority between the two requesters; stalls the CPU while its fetch is pending.
- Sits between the CPU fetch stage, the program-load interface and the instruction memory macro.

---
 rtl/cpu_mem_pkg.sv | 28 ++
 rtl/imem_fetch_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the instruction-memory fetch arbiter.
package cpu_mem_pkg;

   localparam int BYTE_W  = 8;
   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_F_HI  = 3'd1,
      S_F_LO  = 3'd2,
      S_F_CAP = 3'd3,
      S_H_WR  = 3'd4,
      S_H_RD  = 3'd5,
      S_H_CAP = 3'd6
   } state_e;

   typedef enum logic {
      GRANT_FETCH = 1'b0,
      GRANT_HOST  = 1'b1
   } grant_e;

   // Big-endian instruction assembly: first byte read is the high byte.
   function automatic logic [INSTR_W-1:0] assemble_instr(input logic [BYTE_W-1:0] hi,
                                                          input logic [BYTE_W-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/imem_fetch_arbiter.sv
// Sequences a byte-wide single-port instruction memory between CPU fetch
// (two big-endian byte reads) and a host load/debug port, alternating priority.
module imem_fetch_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_req,
   input  logic [ADDR_W-1:0]  fetch_addr,
   output logic               fetch_valid,
   output logic [INSTR_W-1:0] fetch_instr,
   output logic               cpu_stall,
   input  logic               host_req,
   input  logic               host_we,
   input  logic [ADDR_W-1:0]  host_addr,
   input  logic [BYTE_W-1:0]  host_wdata,
   output logic               host_done,
   output logic [BYTE_W-1:0]  host_rdata,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [BYTE_W-1:0]  mem_wdata,
   input  logic [BYTE_W-1:0]  mem_rdata
);

   state_e               state_q, state_d;
   grant_e               last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]    f_addr_q, f_addr_d;
   logic [ADDR_W-1:0]    h_addr_q, h_addr_d;
   logic [BYTE_W-1:0]    h_wdata_q, h_wdata_d;
   logic [BYTE_W-1:0]    hi_q, hi_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [BYTE_W-1:0]    rdata_q, rdata_d;

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= GRANT_HOST;
         f_addr_q     <= {ADDR_W{1'b0}};
         h_addr_q     <= {ADDR_W{1'b0}};
         h_wdata_q    <= {BYTE_W{1'b0}};
         hi_q         <= {BYTE_W{1'b0}};
         instr_q      <= {INSTR_W{1'b0}};
         rdata_q      <= {BYTE_W{1'b0}};
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         f_addr_q     <= f_addr_d;
         h_addr_q     <= h_addr_d;
         h_wdata_q    <= h_wdata_d;
         hi_q         <= hi_d;
         instr_q      <= instr_d;
         rdata_q      <= rdata_d;
      end
   end

   // Next-state, arbitration and byte capture.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      f_addr_d     = f_addr_q;
      h_addr_d     = h_addr_q;
      h_wdata_d    = h_wdata_q;
      hi_d         = hi_q;
      instr_d      = instr_q;
      rdata_d      = rdata_q;
      case (state_q)
         S_IDLE: begin
            // On a tie the requester that did not win last time is served.
            if (fetch_req && (!host_req || last_grant_q == GRANT_HOST)) begin
               state_d      = S_F_HI;
               last_grant_d = GRANT_FETCH;
               f_addr_d     = {fetch_addr[ADDR_W-1:1], 1'b0};
            end else if (host_req) begin
               state_d      = host_we ? S_H_WR : S_H_RD;
               last_grant_d = GRANT_HOST;
               h_addr_d     = host_addr;
               h_wdata_d    = host_wdata;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_F_HI:  state_d = S_F_LO;
         S_F_LO: begin
            state_d = S_F_CAP;
            hi_d    = mem_rdata;
         end
         S_F_CAP: begin
            state_d = S_IDLE;
            instr_d = assemble_instr(hi_q, mem_rdata);
         end
         S_H_WR:  state_d = S_IDLE;
         S_H_RD:  state_d = S_H_CAP;
         S_H_CAP: begin
            state_d = S_IDLE;
            rdata_d = mem_rdata;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the registered state; capture cycles present the
   // arriving byte directly so data is valid alongside its pulse.
   always_comb begin
      fetch_valid = 1'b0;
      host_done   = 1'b0;
      mem_addr    = {ADDR_W{1'b0}};
      mem_we      = 1'b0;
      mem_wdata   = {BYTE_W{1'b0}};
      case (state_q)
         S_F_HI:  mem_addr = f_addr_q;
         S_F_LO:  mem_addr = {f_addr_q[ADDR_W-1:1], 1'b1};
         S_F_CAP: fetch_valid = 1'b1;
         S_H_WR: begin
            mem_addr  = h_addr_q;
            mem_we    = 1'b1;
            mem_wdata = h_wdata_q;
            host_done = 1'b1;
         end
         S_H_RD:  mem_addr = h_addr_q;
         S_H_CAP: host_done = 1'b1;
         default: mem_addr = {ADDR_W{1'b0}};
      endcase
      if (state_q == S_F_CAP) begin
         fetch_instr = assemble_instr(hi_q, mem_rdata);
      end else begin
         fetch_instr = instr_q;
      end
      if (state_q == S_H_CAP) begin
         host_rdata = mem_rdata;
      end else begin
         host_rdata = rdata_q;
      end
   end

   assign cpu_stall = fetch_req & ~fetch_valid;

endmodule
